unique_mru_tracker: RTL
=======================

Name: unique_mru_tracker

Overview:
- Parametrised successor to the fixed 4-entry unique-value history block.
- Keeps a DEPTH-entry list of the most recently seen distinct DATA_W-bit values, with entry 0 the most recent.
- Adds an input valid qualifier, selectable move-to-front on hit, hit/miss/evict reporting, occupancy count and synchronous flush.
- Sits after a sampled data source and feeds downstream de-duplication and statistics logic.

Parameters:
- DATA_W, 8: width of tracked values.
- DEPTH, 4: number of list entries; legal range is 2 or more.
- HIT_PROMOTE, 1: 1 = a hit moves the matching entry to entry 0 (MRU order); 0 = a hit leaves the order unchanged (insertion order).

Ports:
- clk_in, in, 1: the single clock; all state updates on its rising edge.
- reset_n_in, in, 1: asynchronous reset, active-low.
- data_valid_in, in, 1: qualifies data_in.
- data_in, in, DATA_W: sample value.
- flush_in, in, 1: synchronous clear of the list and the input stage.
- out_data_o, out, DEPTH*DATA_W: flattened list; entry k occupies bits [k*DATA_W +: DATA_W].
- out_valid_o, out, DEPTH: bit k = entry k valid.
- count_o, out, $clog2(DEPTH+1): number of valid entries.
- hit_o, out, 1: the sample processed at the last edge matched a valid entry.
- hit_idx_o, out, $clog2(DEPTH): index of the matching entry before the update.
- miss_o, out, 1: the sample processed at the last edge was new and was inserted.
- evict_valid_o, out, 1: a valid entry was pushed out at the last edge.
- evict_data_o, out, DATA_W: value of the evicted entry.

Behaviour:
- Reset (reset_n_in=0, asynchronous): all of the following go to 0 — every entry's data and valid, count_o, hit_o, hit_idx_o, miss_o, evict_valid_o, evict_data_o, and the input stage.
- Stage 1:
  - Edge N: if data_valid_in=1, data_in is registered into s1_data and s1_vld=1; otherwise s1_vld=0.
- Stage 2 (edge N+1, only when s1_vld=1):
  - s1_data is compared against every entry k with valid[k]=1; invalid entries never match.
  - The list, count_o and all flags update on this same edge. List and flags therefore reflect a sample 2 edges after it was presented.
- Miss (no valid entry matches):
  - Entry k takes entry k-1 for k=1..DEPTH-1; entry 0 takes s1_data with valid=1.
  - count_o increments, saturating at DEPTH.
  - miss_o=1, hit_o=0.
  - If valid[DEPTH-1]=1 before the shift: evict_valid_o=1 and evict_data_o = the old entry DEPTH-1 value.
- Hit at index h:
  - hit_o=1, hit_idx_o=h, miss_o=0, evict_valid_o=0.
  - With HIT_PROMOTE=1 and h>0: entries 1..h take entries 0..h-1, and entry 0 takes s1_data. Entries above h and all valid bits are unchanged.
  - With HIT_PROMOTE=0, or h=0: the list is unchanged.
- Flag lifetime:
  - hit_o, miss_o and evict_valid_o are single-cycle pulses; they are 0 on any edge where s1_vld=0.
  - hit_idx_o and evict_data_o hold their last value when their flag is 0.
- Invariants:
  - No two valid entries hold equal data.
  - Valid bits are always a contiguous run starting at entry 0.
  - count_o equals the popcount of out_valid_o.
- flush_in=1 at edge N:
  - All entries' data and valid, count_o, the flags and s1_vld clear to 0.
  - The sample in s1 is discarded, and a data_valid_in presented at the same edge is also discarded.
  - Flush has priority over every other event.
- Back-to-back samples: every cycle is supported at full rate. A sample is compared against the list as already updated by the previous sample.
- Reset asserted mid-stream: the state clears immediately; the first valid sample after reset_n_in rises appears in entry 0 two edges after it is presented.

Test Plan:
- Reset, then send 1,2,3,4 on consecutive cycles (DEPTH=4, HIT_PROMOTE=1) -> after the last update the list is {4,3,2,1}, all valid, count_o=4, four miss_o pulses, no evict.
- Then send 5 -> list {5,4,3,2}, miss_o=1, evict_valid_o=1, evict_data_o=1.
- Then send 3 -> hit_o=1, hit_idx_o=2, list {3,5,4,2}, count_o=4, no evict.
- Repeat the hit case with HIT_PROMOTE=0 -> list stays {5,4,3,2}, hit_idx_o=2.
- Send 1,2,1,2,1 with gaps where data_valid_in=0 -> list {1,2}, count_o=2, out_valid_o=4'b0011, flags are 0 in the idle cycles, and the checker sees no duplicate valid entries.
- flush_in=1 coincident with data_valid_in=1 and data 9 -> next cycle all valid bits 0, count_o=0, and 9 is never inserted.
- Assert reset_n_in low between clock edges with a full list -> outputs are 0 before the next edge.
- 10 random streams of up to 100 samples, DEPTH=8 and DATA_W=4 -> the scoreboard model matches every cycle and the uniqueness/contiguity invariants hold.

Source files
------------

// File: rtl/unique_mru_tracker.sv
// unique_mru_tracker: keeps a DEPTH-entry list of the most recently seen
// distinct DATA_W-bit values (entry 0 = most recent). Samples pass through a
// one-deep input register, then are matched against the list. A miss inserts
// the sample at entry 0 and may evict the oldest entry; a hit optionally moves
// the matching entry to the front.
module unique_mru_tracker #(
    parameter int DATA_W      = 8,
    parameter int DEPTH       = 4,
    parameter int HIT_PROMOTE = 1
) (
    input  logic                            clk_in,
    input  logic                            reset_n_in,
    input  logic                            data_valid_in,
    input  logic [DATA_W-1:0]               data_in,
    input  logic                            flush_in,
    output logic [DEPTH*DATA_W-1:0]         out_data_o,
    output logic [DEPTH-1:0]                out_valid_o,
    output logic [$clog2(DEPTH+1)-1:0]      count_o,
    output logic                            hit_o,
    output logic [$clog2(DEPTH)-1:0]        hit_idx_o,
    output logic                            miss_o,
    output logic                            evict_valid_o,
    output logic [DATA_W-1:0]               evict_data_o
);

    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam int IDX_W = $clog2(DEPTH);

    logic [DEPTH-1:0][DATA_W-1:0] ent_q, ent_d;
    logic [DEPTH-1:0]             vld_q, vld_d;
    logic [CNT_W-1:0]             count_q, count_d;
    logic                         s1_vld_q, s1_vld_d;
    logic [DATA_W-1:0]            s1_data_q, s1_data_d;
    logic                         hit_q, hit_d;
    logic [IDX_W-1:0]             hit_idx_q, hit_idx_d;
    logic                         miss_q, miss_d;
    logic                         evict_valid_q, evict_valid_d;
    logic [DATA_W-1:0]            evict_data_q, evict_data_d;

    logic [DEPTH-1:0]             match;
    logic                         hit_any;
    logic [IDX_W-1:0]             match_idx;

    // Compare the staged sample against every valid entry; invalid entries never match.
    always_comb begin
        match     = '0;
        match_idx = '0;
        for (int k = 0; k < DEPTH; k++) begin
            match[k] = vld_q[k] && (ent_q[k] == s1_data_q);
        end
        // Entries are unique, so at most one bit is set; the encoder order is moot.
        for (int k = DEPTH - 1; k >= 0; k--) begin
            if (match[k]) begin
                match_idx = IDX_W'(k);
            end
        end
        hit_any = |match;
    end

    // Next-state for the input stage, the list, the occupancy and the status flags.
    always_comb begin
        ent_d         = ent_q;
        vld_d         = vld_q;
        count_d       = count_q;
        s1_vld_d      = data_valid_in;
        s1_data_d     = data_valid_in ? data_in : s1_data_q;
        hit_d         = 1'b0;
        hit_idx_d     = hit_idx_q;
        miss_d        = 1'b0;
        evict_valid_d = 1'b0;
        evict_data_d  = evict_data_q;

        if (flush_in) begin
            // Flush wins over everything, including a sample arriving this edge.
            ent_d     = '0;
            vld_d     = '0;
            count_d   = '0;
            s1_vld_d  = 1'b0;
            s1_data_d = '0;
        end else if (s1_vld_q) begin
            if (hit_any) begin
                hit_d     = 1'b1;
                hit_idx_d = match_idx;
                if (HIT_PROMOTE != 0) begin
                    // Rotate entries 0..h by one; entry h is the sample itself.
                    for (int k = 1; k < DEPTH; k++) begin
                        if (k <= int'(match_idx)) begin
                            ent_d[k] = ent_q[k-1];
                        end
                    end
                    ent_d[0] = s1_data_q;
                end
            end else begin
                miss_d = 1'b1;
                if (vld_q[DEPTH-1]) begin
                    evict_valid_d = 1'b1;
                    evict_data_d  = ent_q[DEPTH-1];
                end
                for (int k = 1; k < DEPTH; k++) begin
                    ent_d[k] = ent_q[k-1];
                end
                ent_d[0] = s1_data_q;
                vld_d    = {vld_q[DEPTH-2:0], 1'b1};
                if (count_q != CNT_W'(DEPTH)) begin
                    count_d = count_q + CNT_W'(1);
                end
            end
        end
    end

    // State registers with asynchronous active-low clear.
    always_ff @(posedge clk_in or negedge reset_n_in) begin
        if (!reset_n_in) begin
            ent_q         <= '0;
            vld_q         <= '0;
            count_q       <= '0;
            s1_vld_q      <= 1'b0;
            s1_data_q     <= '0;
            hit_q         <= 1'b0;
            hit_idx_q     <= '0;
            miss_q        <= 1'b0;
            evict_valid_q <= 1'b0;
            evict_data_q  <= '0;
        end else begin
            ent_q         <= ent_d;
            vld_q         <= vld_d;
            count_q       <= count_d;
            s1_vld_q      <= s1_vld_d;
            s1_data_q     <= s1_data_d;
            hit_q         <= hit_d;
            hit_idx_q     <= hit_idx_d;
            miss_q        <= miss_d;
            evict_valid_q <= evict_valid_d;
            evict_data_q  <= evict_data_d;
        end
    end

    assign out_data_o    = ent_q;
    assign out_valid_o   = vld_q;
    assign count_o       = count_q;
    assign hit_o         = hit_q;
    assign hit_idx_o     = hit_idx_q;
    assign miss_o        = miss_q;
    assign evict_valid_o = evict_valid_q;
    assign evict_data_o  = evict_data_q;

endmodule
